cphy_hs_sequencer: RTL
======================

Name: cphy_hs_sequencer

Overview:
HS burst sequencer for one C-PHY TX lane. It generates the preamble, the sync word and the post sequence as 3-bit symbol codes, and raises the Pre_Done, Sync_Done and Post_Done handshakes consumed by cphy_tx_fsm. It is enabled by the FSM's Sequencer_En, Sync and Post outputs. Its symbol output feeds the serializer mux when HSSerSeqSel selects the sequencer.

Parameters:
PREBEGIN_W, 8, width of PreBeginLen (preamble begin length in 7-symbol units)
POST_W, 4, width of PostLen (post length in 7-symbol units)

Ports:
clk  in  1  lane HS word clock, one symbol per cycle
rst_n  in  1  asynchronous active-low reset
Sequencer_En  in  1  from FSM; high for the whole HS burst; low aborts
Sync  in  1  from FSM; request one sync word
Post  in  1  from FSM; request the post sequence
PreBeginLen  in  PREBEGIN_W  PREBEGIN length in 7-symbol units; 0 treated as 1
ProgSeqEn  in  1  insert the 14-symbol programmable sequence
ProgSeq  in  42  14 symbols × 3 bits; symbol i = ProgSeq[3i+2:3i]
PostLen  in  POST_W  POST length in 7-symbol units; 0 treated as 1
Seq_Symbol  out  3  symbol code, 0..4
Seq_Valid  out  1  Seq_Symbol is driving the lane
Pre_Done  out  1  1-cycle pulse
Sync_Done  out  1  1-cycle pulse
Post_Done  out  1  1-cycle pulse
Seq_Busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE; Seq_Symbol=0, Seq_Valid=0, all Done=0, Seq_Busy=0; counters=0.
- All outputs are registered. The first symbol appears the cycle after the triggering input is sampled.
- PreBeginLen, ProgSeqEn, ProgSeq and PostLen are latched on entry to PREBEGIN or POST. Changes mid-phase are ignored.
- State machine: IDLE, PREBEGIN, PROGSEQ, PREEND, HOLD, SYNC, POST.
- IDLE: Seq_Valid=0. When Sequencer_En=1 → PREBEGIN.
- PREBEGIN: emits symbol 3 for 7·max(PreBeginLen,1) cycles. Then → PROGSEQ if ProgSeqEn, else → PREEND.
- PROGSEQ: emits ProgSeq symbols 0..13 in order, one per cycle, 14 cycles. Then → PREEND.
- PREEND: emits symbol 3 for 7 cycles. Pre_Done=1 in the same cycle as the 7th symbol. Then → HOLD.
- HOLD: Seq_Valid=0, Seq_Symbol=0; the data path owns the lane.
  - Sync=1 → SYNC.
  - Post=1 → POST.
  - Both high: Sync wins; Post is re-evaluated after the sync word.
- SYNC: emits 3,4,4,4,4,4,3 (7 cycles). Sync_Done=1 in the same cycle as the last symbol. Then → HOLD. Sync held high re-triggers another sync word back-to-back with no gap cycle.
- POST: emits symbol 4 for 7·max(PostLen,1) cycles. Post_Done=1 in the same cycle as the last symbol. Then → IDLE.
- Seq_Valid=1 exactly in PREBEGIN, PROGSEQ, PREEND, SYNC and POST cycles.
- Sync or Post asserted in IDLE, PREBEGIN, PROGSEQ or PREEND: ignored, no queuing.
- Sequencer_En=0 in any non-IDLE state: next cycle state=IDLE, Seq_Valid=0, no Done pulse, counters cleared.
- A Done pulse is never longer than 1 cycle, even if the FSM leaves its request input high.
- Symbol counter is 11 bits wide, sufficient for 7·255 + 14 + 7. Saturation or wrap is not reachable.
- Reset asserted mid-burst: immediate return to reset values. A subsequent burst restarts cleanly at PREBEGIN.

Test Plan:
- Reset then PreBeginLen=2, ProgSeqEn=0, raise Sequencer_En → 21 consecutive cycles of Seq_Symbol=3 with Seq_Valid=1; Pre_Done high only on cycle 21; then Seq_Valid=0 (HOLD).
- ProgSeqEn=1, PreBeginLen=1, ProgSeq = symbols 0,1,2,3,4,0,1,2,3,4,0,1,2,3 → 7×3, then that 14-symbol order, then 7×3; Pre_Done on cycle 28.
- In HOLD pulse Sync for 1 cycle → 3,4,4,4,4,4,3 with Sync_Done on the 7th; hold Sync for 8 cycles → two back-to-back sync words, two Sync_Done pulses 7 cycles apart.
- In HOLD assert Sync and Post together, PostLen=0 → sync word, then 7×symbol 4; Post_Done on the last cycle; Seq_Busy=0 the next cycle.
- Drop Sequencer_En at PREBEGIN cycle 5 → Seq_Valid=0 the next cycle; no Pre_Done; re-assert → full preamble restarts from cycle 1.
- Assert rst_n=0 mid-POST, asynchronously between edges → outputs zero immediately; Post_Done never asserted.

Source files
------------

// File: rtl/cphy_hs_sequencer.sv
// HS burst sequencer for one C-PHY TX lane.
// Produces the preamble (PREBEGIN, optional programmable sequence, PREEND),
// sync words and the post sequence as 3-bit symbol codes, one per clock.
// Raises the Pre_Done / Sync_Done / Post_Done handshakes for cphy_tx_fsm.
//
// Handshake semantics: Sequencer_En is a level; it is high for the whole burst
// and dropping it aborts to IDLE on the next edge with no Done pulse. Sync and
// Post are levels sampled only in HOLD or on the last symbol of a sync word;
// elsewhere they are ignored, never queued. Each Done output is a single-cycle
// pulse coincident with the final symbol of its phase, whatever the request
// levels do afterwards.
//
// Every output is a flop. Next-state logic computes the state, counter and the
// symbol for the coming cycle, so the first symbol of a phase appears on the
// cycle after the triggering input is sampled.
module cphy_hs_sequencer #(
    parameter int PREBEGIN_W = 8,
    parameter int POST_W     = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  Sequencer_En,
    input  logic                  Sync,
    input  logic                  Post,
    input  logic [PREBEGIN_W-1:0] PreBeginLen,
    input  logic                  ProgSeqEn,
    input  logic [41:0]           ProgSeq,
    input  logic [POST_W-1:0]     PostLen,
    output logic [2:0]            Seq_Symbol,
    output logic                  Seq_Valid,
    output logic                  Pre_Done,
    output logic                  Sync_Done,
    output logic                  Post_Done,
    output logic                  Seq_Busy
);

    // Symbol counter width: enough for 7*255 + 14 + 7 symbols.
    localparam int CNT_W = 11;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_PREBEGIN = 3'd1;
    localparam logic [2:0] ST_PROGSEQ  = 3'd2;
    localparam logic [2:0] ST_PREEND   = 3'd3;
    localparam logic [2:0] ST_HOLD     = 3'd4;
    localparam logic [2:0] ST_SYNC     = 3'd5;
    localparam logic [2:0] ST_POST     = 3'd6;

    // Symbol codes used by the fixed sequences.
    localparam logic [2:0] SYM_THREE = 3'd3;
    localparam logic [2:0] SYM_FOUR  = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] pre_total_q, pre_total_d;
    logic [CNT_W-1:0] post_total_q, post_total_d;
    logic             prog_en_q, prog_en_d;
    logic [41:0]      prog_seq_q, prog_seq_d;

    logic [2:0]       sym_q, sym_d;
    logic             valid_q, valid_d;
    logic             pre_done_q, pre_done_d;
    logic             sync_done_q, sync_done_d;
    logic             post_done_q, post_done_d;
    logic             busy_q, busy_d;

    // Lengths in symbols as they would be latched right now (0 counts as 1).
    logic [PREBEGIN_W-1:0] pre_units;
    logic [POST_W-1:0]     post_units;
    logic [CNT_W-1:0]      pre_total_new;
    logic [CNT_W-1:0]      post_total_new;

    // Programmable-sequence symbol selection for the coming cycle.
    logic [3:0]            prog_idx_next;
    logic [5:0]            prog_base;

    // Set when the next state must be chosen from the Sync/Post requests.
    logic                  hold_decide;

    // Convert the 7-symbol unit lengths into symbol counts.
    always_comb begin
        pre_units      = (PreBeginLen == '0) ? PREBEGIN_W'(1) : PreBeginLen;
        post_units     = (PostLen == '0) ? POST_W'(1) : PostLen;
        pre_total_new  = CNT_W'(pre_units) * CNT_W'(7);
        post_total_new = CNT_W'(post_units) * CNT_W'(7);
        prog_idx_next  = cnt_q[3:0] + 4'd1;
        prog_base      = {2'b00, prog_idx_next} * 6'd3;
    end

    // Next-state, counter, latched configuration and registered-output logic.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pre_total_d  = pre_total_q;
        post_total_d = post_total_q;
        prog_en_d    = prog_en_q;
        prog_seq_d   = prog_seq_q;
        sym_d        = 3'd0;
        valid_d      = 1'b0;
        pre_done_d   = 1'b0;
        sync_done_d  = 1'b0;
        post_done_d  = 1'b0;
        hold_decide  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (Sequencer_En) begin
                    state_d     = ST_PREBEGIN;
                    cnt_d       = '0;
                    pre_total_d = pre_total_new;
                    prog_en_d   = ProgSeqEn;
                    prog_seq_d  = ProgSeq;
                    sym_d       = SYM_THREE;
                    valid_d     = 1'b1;
                end
            end

            ST_PREBEGIN: begin
                valid_d = 1'b1;
                if (cnt_q == pre_total_q - 11'd1) begin
                    cnt_d = '0;
                    if (prog_en_q) begin
                        state_d = ST_PROGSEQ;
                        sym_d   = prog_seq_q[2:0];
                    end else begin
                        state_d = ST_PREEND;
                        sym_d   = SYM_THREE;
                    end
                end else begin
                    cnt_d = cnt_q + 11'd1;
                    sym_d = SYM_THREE;
                end
            end

            ST_PROGSEQ: begin
                valid_d = 1'b1;
                if (cnt_q == 11'd13) begin
                    state_d = ST_PREEND;
                    cnt_d   = '0;
                    sym_d   = SYM_THREE;
                end else begin
                    cnt_d = cnt_q + 11'd1;
                    sym_d = prog_seq_q[prog_base +: 3];
                end
            end

            ST_PREEND: begin
                if (cnt_q == 11'd6) begin
                    // Requests seen on the last PREEND cycle are not honoured.
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d      = cnt_q + 11'd1;
                    sym_d      = SYM_THREE;
                    valid_d    = 1'b1;
                    pre_done_d = (cnt_q == 11'd5);
                end
            end

            ST_HOLD: begin
                hold_decide = 1'b1;
            end

            ST_SYNC: begin
                if (cnt_q == 11'd6) begin
                    // Last sync symbol: behave like HOLD so a held Sync chains
                    // the next word with no gap.
                    hold_decide = 1'b1;
                end else begin
                    cnt_d       = cnt_q + 11'd1;
                    sym_d       = (cnt_q == 11'd5) ? SYM_THREE : SYM_FOUR;
                    valid_d     = 1'b1;
                    sync_done_d = (cnt_q == 11'd5);
                end
            end

            ST_POST: begin
                if (cnt_q == post_total_q - 11'd1) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d       = cnt_q + 11'd1;
                    sym_d       = SYM_FOUR;
                    valid_d     = 1'b1;
                    post_done_d = (cnt_q == post_total_q - 11'd2);
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Sync has priority; Post is looked at again after the sync word.
        if (hold_decide) begin
            cnt_d = '0;
            if (Sync) begin
                state_d = ST_SYNC;
                sym_d   = SYM_THREE;
                valid_d = 1'b1;
            end else if (Post) begin
                state_d      = ST_POST;
                post_total_d = post_total_new;
                sym_d        = SYM_FOUR;
                valid_d      = 1'b1;
            end else begin
                state_d = ST_HOLD;
            end
        end

        // Abort: dropping the enable returns to IDLE with a silent lane.
        if ((state_q != ST_IDLE) && !Sequencer_En) begin
            state_d     = ST_IDLE;
            cnt_d       = '0;
            sym_d       = 3'd0;
            valid_d     = 1'b0;
            pre_done_d  = 1'b0;
            sync_done_d = 1'b0;
            post_done_d = 1'b0;
        end
    end

    // Busy mirrors the registered state so it lines up with the outputs.
    always_comb begin
        busy_d = (state_d != ST_IDLE);
    end

    // State, counter, configuration and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            pre_total_q  <= '0;
            post_total_q <= '0;
            prog_en_q    <= 1'b0;
            prog_seq_q   <= '0;
            sym_q        <= 3'd0;
            valid_q      <= 1'b0;
            pre_done_q   <= 1'b0;
            sync_done_q  <= 1'b0;
            post_done_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pre_total_q  <= pre_total_d;
            post_total_q <= post_total_d;
            prog_en_q    <= prog_en_d;
            prog_seq_q   <= prog_seq_d;
            sym_q        <= sym_d;
            valid_q      <= valid_d;
            pre_done_q   <= pre_done_d;
            sync_done_q  <= sync_done_d;
            post_done_q  <= post_done_d;
            busy_q       <= busy_d;
        end
    end

    assign Seq_Symbol = sym_q;
    assign Seq_Valid  = valid_q;
    assign Pre_Done   = pre_done_q;
    assign Sync_Done  = sync_done_q;
    assign Post_Done  = post_done_q;
    assign Seq_Busy   = busy_q;

endmodule
